// File: rtl/axi_lite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_arbiter
//   Shares one AXI-lite SRAM slave between the IFU (M0, read only) and the
//   LSU (M1, read/write). A request is accepted only in IDLE. It is latched
//   and then replayed to the slave as exactly one transaction. The response
//   is steered back to the master that owns the transaction.
//
// Handshake rule (every channel): a transfer happens on a rising clk edge
//   where valid && ready are both 1. A valid, once raised by the arbiter,
//   stays high with stable payload until its transfer.
//
// Configuration macro: ARB_RR_EN
//   defined   -> contention between M0 and M1 is round-robin on r_rr_last
//   undefined -> fixed priority, M1 beats M0
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   m0_ar*, m0_r*        IFU read channels
//   m1_ar*, m1_r*        LSU read channels
//   m1_aw*, m1_w*, m1_b* LSU write channels
//   s_*                  channels toward the SRAM slave
//   o_dbg_state          FSM state (0 IDLE, 1 RD, 2 WR)
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS 3:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif

module axi_lite_mem_arbiter (
  input  logic                  clk,
  input  logic                  rst_n,
  // M0 (IFU)
  input  logic [`AXI_ADDR_BUS]  m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [`AXI_DATA_BUS]  m0_rdata,
  output logic [`AXI_RESP_BUS]  m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // M1 (LSU)
  input  logic [`AXI_ADDR_BUS]  m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [`AXI_DATA_BUS]  m1_rdata,
  output logic [`AXI_RESP_BUS]  m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [`AXI_ADDR_BUS]  m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [`AXI_DATA_BUS]  m1_wdata,
  input  logic [`AXI_WSTRB_BUS] m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [`AXI_RESP_BUS]  m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // SRAM slave
  output logic [`AXI_ADDR_BUS]  s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [`AXI_DATA_BUS]  s_rdata,
  input  logic [`AXI_RESP_BUS]  s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [`AXI_ADDR_BUS]  s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [`AXI_DATA_BUS]  s_wdata,
  output logic [`AXI_WSTRB_BUS] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [`AXI_RESP_BUS]  s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  // Debug
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t                r_state;
  logic                  r_owner;     // 0 = M0, 1 = M1
  logic [`AXI_ADDR_BUS]  r_addr;
  logic [`AXI_DATA_BUS]  r_wdata;
  logic [`AXI_WSTRB_BUS] r_wstrb;
  logic                  r_ar_done;
  logic                  r_aw_done;
  logic                  r_w_done;
`ifdef ARB_RR_EN
  logic                  r_rr_last;   // owner of the most recent grant
`endif

  logic w_wr1, w_m1_req, w_pick_m1, w_idle;
  logic w_gnt_wr, w_gnt_rd1, w_gnt_rd0;
  logic w_rd, w_wr, w_rd0, w_rd1;

  // An AW without its W (or vice versa) is not a write request.
  assign w_wr1    = m1_awvalid && m1_wvalid;
  assign w_m1_req = w_wr1 || m1_arvalid;

`ifdef ARB_RR_EN
  // Under contention M1 wins only if M0 owned the previous grant.
  assign w_pick_m1 = w_m1_req && (!m0_arvalid || !r_rr_last);
`else
  assign w_pick_m1 = w_m1_req;
`endif

  // rst_n gating keeps the combinational grants quiet while held in reset.
  assign w_idle    = (r_state == IDLE) && rst_n;
  assign w_gnt_wr  = w_idle && w_pick_m1 && w_wr1;
  assign w_gnt_rd1 = w_idle && w_pick_m1 && !w_wr1;
  assign w_gnt_rd0 = w_idle && !w_pick_m1 && m0_arvalid;

  assign m0_arready = w_gnt_rd0;
  assign m1_arready = w_gnt_rd1;
  assign m1_awready = w_gnt_wr;
  assign m1_wready  = w_gnt_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef ARB_RR_EN
      r_rr_last <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_gnt_wr) begin
            r_state <= WR;
            r_owner <= 1'b1;
            r_addr  <= m1_awaddr;
            r_wdata <= m1_wdata;
            r_wstrb <= m1_wstrb;
          end else if (w_gnt_rd1) begin
            r_state <= RD;
            r_owner <= 1'b1;
            r_addr  <= m1_araddr;
          end else if (w_gnt_rd0) begin
            r_state <= RD;
            r_owner <= 1'b0;
            r_addr  <= m0_araddr;
          end
`ifdef ARB_RR_EN
          if (w_gnt_wr || w_gnt_rd1) r_rr_last <= 1'b1;
          else if (w_gnt_rd0)        r_rr_last <= 1'b0;
`endif
        end
        RD: begin
          if (s_arvalid && s_arready) r_ar_done <= 1'b1;
          if (s_rvalid && s_rready)   r_state   <= IDLE;
        end
        WR: begin
          if (s_awvalid && s_awready) r_aw_done <= 1'b1;
          if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
          if (s_bvalid && s_bready)   r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd  = (r_state == RD);
  assign w_wr  = (r_state == WR);
  assign w_rd0 = w_rd && !r_owner;
  assign w_rd1 = w_rd && r_owner;

  // Slave side
  assign s_araddr  = r_addr;
  assign s_arvalid = w_rd && !r_ar_done;
  assign s_rready  = w_rd && (r_owner ? m1_rready : m0_rready);
  assign s_awaddr  = r_addr;
  assign s_awvalid = w_wr && !r_aw_done;
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign s_wvalid  = w_wr && !r_w_done;
  assign s_bready  = w_wr && m1_bready;

  // Response steering; unrouted payloads read as zero.
  assign m0_rvalid = w_rd0 && s_rvalid;
  assign m0_rdata  = w_rd0 ? s_rdata : '0;
  assign m0_rresp  = w_rd0 ? s_rresp : '0;
  assign m1_rvalid = w_rd1 && s_rvalid;
  assign m1_rdata  = w_rd1 ? s_rdata : '0;
  assign m1_rresp  = w_rd1 ? s_rresp : '0;
  assign m1_bvalid = w_wr && s_bvalid;
  assign m1_bresp  = w_wr ? s_bresp : '0;

  assign o_dbg_state = r_state;

endmodule
